// File: rtl/traffic_pkg.sv
// Shared types for the intersection sequencer: state encoding and lamp vectors.
// Lamp vectors are laid out as {red, yellow, green}.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5,
        WALK      = 3'd6,
        FLASH     = 3'd7
    } state_e;

    localparam int RED    = 2;
    localparam int YELLOW = 1;
    localparam int GREEN  = 0;

    localparam logic [2:0] LAMP_RED = 3'(1 << RED);
    localparam logic [2:0] LAMP_YEL = 3'(1 << YELLOW);
    localparam logic [2:0] LAMP_GRN = 3'(1 << GREEN);
    localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// Seconds-remaining counter for the current phase. A load wins over a tick;
// 'last' flags the tick that ends the phase (tick while count is 1).
module phase_timer #(
    parameter logic [7:0] RST_VAL = 8'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic [7:0] count,
    output logic       last
);

    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= RST_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick && count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign count = count_q;
    assign last  = tick && (count_q == 8'd1);

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road intersection sequencer stepped by a 1 Hz tick enable, with night flashing.
// Define PED_WALK_EN to compile in the pedestrian request latch and WALK phase.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_SEC  = 5,
    parameter int unsigned YELLOW_SEC = 2,
    parameter int unsigned ALLRED_SEC = 1,
    parameter int unsigned WALK_SEC   = 3
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       night_mode,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [7:0] secs_left,
    output logic [2:0] state_o
);

    generate
        if (GREEN_SEC < 1 || GREEN_SEC > 255 || YELLOW_SEC < 1 || YELLOW_SEC > 255 ||
            ALLRED_SEC < 1 || ALLRED_SEC > 255 || WALK_SEC < 1 || WALK_SEC > 255) begin : g_bad_param
            $error("traffic_light_fsm: phase durations must lie in 1..255");
        end
    endgenerate

    function automatic logic [7:0] dur(input state_e s);
        case (s)
            NS_GREEN, EW_GREEN:   dur = 8'(GREEN_SEC);
            NS_YELLOW, EW_YELLOW: dur = 8'(YELLOW_SEC);
            ALL_RED_1, ALL_RED_2: dur = 8'(ALLRED_SEC);
            WALK:                 dur = 8'(WALK_SEC);
            default:              dur = 8'd0;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic       flash_q, flash_d;
    logic [2:0] ns_q, ns_d, ew_q, ew_d;
    logic       timer_load, timer_last;
    logic [7:0] timer_val, timer_count;

`ifdef PED_WALK_EN
    logic ped_q, ped_d;
    logic ret_ew_q, ret_ew_d;   // green to resume after WALK: 1 = EW, 0 = NS
    logic walk_q, walk_d;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    phase_timer #(
        .RST_VAL (8'(GREEN_SEC))
    ) u_timer (
        .clk      (clk_in),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (tick_1hz),
        .count    (timer_count),
        .last     (timer_last)
    );

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q <= NS_GREEN;
            flash_q <= 1'b0;
            ns_q    <= LAMP_GRN;
            ew_q    <= LAMP_RED;
`ifdef PED_WALK_EN
            ped_q    <= 1'b0;
            ret_ew_q <= 1'b0;
            walk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            flash_q <= flash_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
`ifdef PED_WALK_EN
            ped_q    <= ped_d;
            ret_ew_q <= ret_ew_d;
            walk_q   <= walk_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        flash_d    = flash_q;
        timer_load = 1'b0;
        timer_val  = 8'd0;
`ifdef PED_WALK_EN
        ped_d    = ped_q | ped_req;
        ret_ew_d = ret_ew_q;
`endif
        if (tick_1hz && night_mode) begin
            state_d    = FLASH;
            flash_d    = (state_q == FLASH) ? ~flash_q : 1'b1;
            timer_load = 1'b1;
        end else if (tick_1hz && state_q == FLASH) begin
            state_d    = ALL_RED_2;
            flash_d    = 1'b0;
            timer_load = 1'b1;
            timer_val  = dur(ALL_RED_2);
        end else if (timer_last) begin
            case (state_q)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: state_d = ALL_RED_1;
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: state_d = ALL_RED_2;
                ALL_RED_1: begin
                    state_d = EW_GREEN;
`ifdef PED_WALK_EN
                    if (ped_q || ped_req) begin
                        state_d  = WALK;
                        ret_ew_d = 1'b1;
                        ped_d    = 1'b0;
                    end
`endif
                end
                ALL_RED_2: begin
                    state_d = NS_GREEN;
`ifdef PED_WALK_EN
                    if (ped_q || ped_req) begin
                        state_d  = WALK;
                        ret_ew_d = 1'b0;
                        ped_d    = 1'b0;
                    end
`endif
                end
`ifdef PED_WALK_EN
                WALK:      state_d = ret_ew_q ? EW_GREEN : NS_GREEN;
`endif
                default:   state_d = state_q;
            endcase
            timer_load = 1'b1;
            timer_val  = dur(state_d);
        end
    end

    // Lamps are decoded from the next state so they land in registers on the same edge.
    always_comb begin
        ns_d = LAMP_RED;
        ew_d = LAMP_RED;
`ifdef PED_WALK_EN
        walk_d = (state_d == WALK);
`endif
        case (state_d)
            NS_GREEN:  ns_d = LAMP_GRN;
            NS_YELLOW: ns_d = LAMP_YEL;
            EW_GREEN:  ew_d = LAMP_GRN;
            EW_YELLOW: ew_d = LAMP_YEL;
            FLASH: begin
                ns_d = flash_d ? LAMP_YEL : LAMP_OFF;
                ew_d = flash_d ? LAMP_RED : LAMP_OFF;
            end
            default: ;
        endcase
    end

    assign ns_light  = ns_q;
    assign ew_light  = ew_q;
    assign secs_left = timer_count;
    assign state_o   = state_q;
`ifdef PED_WALK_EN
    assign walk = walk_q;
`else
    assign walk = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with default durations (5/2/1/3).
// Follows the PED_WALK_EN define of the build it is compiled with.
module tb_traffic_light_fsm;
    import traffic_pkg::*;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       night_mode = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light, ew_light, state_o;
    logic       walk;
    logic [7:0] secs_left;

    int total = 0;
    int passed = 0;
    int failed = 0;

`ifdef PED_WALK_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    traffic_light_fsm dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .night_mode (night_mode),
        .ped_req    (ped_req),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .walk       (walk),
        .secs_left  (secs_left),
        .state_o    (state_o)
    );

    always #10 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_ns(input logic [2:0] st);
        case (st)
            3'd0:    exp_ns = 3'b001;
            3'd1:    exp_ns = 3'b010;
            default: exp_ns = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew(input logic [2:0] st);
        case (st)
            3'd3:    exp_ew = 3'b001;
            3'd4:    exp_ew = 3'b010;
            default: exp_ew = 3'b100;
        endcase
    endfunction

    // Full check of a timed (non-flash) phase.
    task automatic chk_phase(input string tag, input logic [2:0] st, input logic [7:0] secs, input logic w);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".secs"}, 32'(secs_left), 32'(secs));
        chk({tag, ".ns"}, 32'(ns_light), 32'(exp_ns(st)));
        chk({tag, ".ew"}, 32'(ew_light), 32'(exp_ew(st)));
        chk({tag, ".walk"}, 32'(walk), 32'(w));
        chk({tag, ".conflict"}, 32'((ns_light[1:0] != 2'b00) && (ew_light[1:0] != 2'b00)), 32'd0);
    endtask

    task automatic do_tick(input logic ped);
        @(negedge clk_in);
        tick_1hz = 1'b1;
        ped_req  = ped;
        @(negedge clk_in);
        tick_1hz = 1'b0;
        ped_req  = 1'b0;
        $display("tick: state=%0d secs=%0d ns=%b ew=%b walk=%b", state_o, secs_left, ns_light, ew_light, walk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0);
    endtask

    logic [2:0] seq_st   [16] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3,
                                  3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
    logic [7:0] seq_secs [16] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd5,
                                  8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd5};
`ifdef PED_WALK_EN
    logic [2:0] ped_st   [11] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd6, 3'd6, 3'd6, 3'd3};
    logic [7:0] ped_secs [11] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd3, 8'd2, 8'd1, 8'd5};
`endif

    initial begin
        logic [23:0] snap;
        logic        changed;

        // Reset
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        $display("reset released");
        chk_phase("reset", 3'd0, 8'd5, 1'b0);

        // Normal cycle; without PED_WALK_EN every tick also carries a ped_req pulse
        for (int i = 0; i < 16; i++) begin
            do_tick(!PED_EN);
            chk_phase($sformatf("cycle_t%0d", i + 1), seq_st[i], seq_secs[i], 1'b0);
        end

`ifdef PED_WALK_EN
        // Pedestrian request on tick 3 -> WALK after ALL_RED_1, then EW_GREEN
        for (int i = 0; i < 11; i++) begin
            do_tick(i == 2);
            chk_phase($sformatf("ped_t%0d", i + 1), ped_st[i], ped_secs[i], ped_st[i] == 3'd6);
        end
        ticks(8);
        chk_phase("ped_return", 3'd0, 8'd5, 1'b0);
`endif

        // Night mode mid EW_GREEN
        ticks(9);
        chk_phase("night_pre", 3'd3, 8'd4, 1'b0);
        night_mode = 1'b1;
        repeat (5) @(negedge clk_in);
        chk_phase("night_notick", 3'd3, 8'd4, 1'b0);
        do_tick(1'b0);
        chk("flash1.state", 32'(state_o), 32'd7);
        chk("flash1.secs", 32'(secs_left), 32'd0);
        chk("flash1.ns", 32'(ns_light), 32'b010);
        chk("flash1.ew", 32'(ew_light), 32'b100);
        do_tick(1'b0);
        chk("flash2.state", 32'(state_o), 32'd7);
        chk("flash2.ns", 32'(ns_light), 32'b000);
        chk("flash2.ew", 32'(ew_light), 32'b000);
        do_tick(1'b0);
        chk("flash3.ns", 32'(ns_light), 32'b010);
        night_mode = 1'b0;
        do_tick(1'b0);
        chk_phase("night_exit", 3'd5, 8'd1, 1'b0);
        do_tick(1'b0);
        chk_phase("night_resume", 3'd0, 8'd5, 1'b0);

        // Reset during EW_YELLOW with a pending pedestrian request
        ticks(13);
        chk_phase("rst_pre", 3'd4, 8'd2, 1'b0);
        @(negedge clk_in);
        ped_req = 1'b1;
        @(negedge clk_in);
        ped_req = 1'b0;
        reset   = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;
        $display("mid-phase reset pulse");
        chk_phase("rst_post", 3'd0, 8'd5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_tick(1'b0);
            chk($sformatf("rst_walk_t%0d", i + 1), 32'(walk), 32'd0);
        end
        chk_phase("rst_no_walk", 3'd3, 8'd5, 1'b0);

        // No ticks for 1000 cycles -> nothing moves
        snap    = {state_o, secs_left, ns_light, ew_light, walk, 2'b00};
        changed = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_in);
            if ({state_o, secs_left, ns_light, ew_light, walk, 2'b00} !== snap) changed = 1'b1;
        end
        $display("idle 1000 cycles done");
        chk("idle_stable", 32'(changed), 32'd0);

        // Night tick on the last second of EW_GREEN beats the phase transition
        ticks(4);
        chk_phase("prio_pre", 3'd3, 8'd1, 1'b0);
        night_mode = 1'b1;
        do_tick(1'b0);
        chk("prio.state", 32'(state_o), 32'd7);
        chk("prio.secs", 32'(secs_left), 32'd0);
        chk("prio.ns", 32'(ns_light), 32'b010);
        night_mode = 1'b0;
        do_tick(1'b0);
        chk_phase("prio_exit", 3'd5, 8'd1, 1'b0);
        do_tick(1'b0);
        chk_phase("prio_resume", 3'd0, 8'd5, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
